// File: rtl/complex_div.sv
// complex_div: sequential Q1.31 complex divider, q = a * conj(b) / |b|^2.
// One MULT cycle forms both numerators and the shared denominator. Two
// restoring dividers (re, im) then produce one quotient bit per cycle, and
// the first DONE cycle applies sign and saturation before presenting the result.
// Build option: define COMPLEX_DIV_ROUND_EN to run one extra iteration for a
// guard bit and round half away from zero (normal latency 35 instead of 34).
module complex_div #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 31
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] a_i,
    input  logic [2*WIDTH-1:0] b_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] q_o,
    output logic               ovf_o,
    output logic               dbz_o
);

    // Product width holds a sum of two full-scale products (up to 2^63, signed).
    localparam int PW = 2*WIDTH + 1;
    // Remainder width leaves headroom for the doubling step of the divider.
    localparam int RW = 2*WIDTH + 2;
`ifdef COMPLEX_DIV_ROUND_EN
    localparam int ITERS = WIDTH + 1;
`else
    localparam int ITERS = WIDTH;
`endif
    localparam int CW = $clog2(ITERS + 1);

    // Largest magnitudes representable in Q1.FRAC for each sign.
    localparam logic [WIDTH:0]   NEG_LIM = (WIDTH+1)'(1) << FRAC;
    localparam logic [WIDTH:0]   POS_LIM = NEG_LIM - (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        DONE
    } state_t;

    state_t state;

    // Captured operands.
    logic signed [WIDTH-1:0] a_re, a_im, b_re, b_im;

    // Divider state.
    logic [2*WIDTH-1:0] den;
    logic               den_zero;
    logic               neg_re, neg_im;
    logic               pre_ovf_re, pre_ovf_im;
    logic [RW-1:0]      rem_re, rem_im;
    logic [ITERS-1:0]   quot_re, quot_im;
    logic [CW-1:0]      cnt;

    // MULT-stage combinational products.
    logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;
    logic signed [PW-1:0] num_re_c, num_im_c, den_c;
    logic [PW-1:0]        mag_re_c, mag_im_c;
    logic                 den_zero_c;

    logic [RW:0]    step_re, step_im;
    logic [WIDTH:0] res_re, res_im;
    logic           accept;

    // One restoring step: subtract den when it fits, emit the bit, double the remainder.
    function automatic logic [RW:0] div_step(input logic [RW-1:0] rem,
                                             input logic [2*WIDTH-1:0] d);
        logic [RW-1:0] dx;
        dx = {2'b00, d};
        if (rem >= dx) begin
            return {1'b1, (rem - dx) << 1};
        end
        return {1'b0, rem << 1};
    endfunction

    // Quotient magnitude; with rounding the LSB shifted in is the guard bit.
    function automatic logic [WIDTH:0] quot_mag(input logic [ITERS-1:0] quot);
`ifdef COMPLEX_DIV_ROUND_EN
        return {1'b0, quot[ITERS-1:1]} + {{WIDTH{1'b0}}, quot[0]};
`else
        return {1'b0, quot};
`endif
    endfunction

    // Apply the sign and clamp to Q1.FRAC; MSB of the result is the saturation flag.
    function automatic logic [WIDTH:0] saturate(input logic [WIDTH:0] mag,
                                                input logic neg,
                                                input logic pre_ovf);
        if (neg) begin
            if (pre_ovf || mag > NEG_LIM) begin
                return {1'b1, MIN_NEG};
            end
            return {1'b0, -mag[WIDTH-1:0]};
        end
        if (pre_ovf || mag > POS_LIM) begin
            return {1'b1, MAX_POS};
        end
        return {1'b0, mag[WIDTH-1:0]};
    endfunction

    // With a zero divisor both numerators vanish, so the direction of the
    // saturated result is taken from the dividend component itself.
    function automatic logic [WIDTH-1:0] dbz_val(input logic signed [WIDTH-1:0] x);
        if (x > 0) begin
            return MAX_POS;
        end
        if (x < 0) begin
            return MIN_NEG;
        end
        return '0;
    endfunction

    assign accept = in_valid && in_ready;

    assign ar_x = {{(PW-WIDTH){a_re[WIDTH-1]}}, a_re};
    assign ai_x = {{(PW-WIDTH){a_im[WIDTH-1]}}, a_im};
    assign br_x = {{(PW-WIDTH){b_re[WIDTH-1]}}, b_re};
    assign bi_x = {{(PW-WIDTH){b_im[WIDTH-1]}}, b_im};

    assign num_re_c   = ar_x * br_x + ai_x * bi_x;
    assign num_im_c   = ai_x * br_x - ar_x * bi_x;
    assign den_c      = br_x * br_x + bi_x * bi_x;
    assign den_zero_c = (den_c == '0);

    assign mag_re_c = num_re_c[PW-1] ? -num_re_c : num_re_c;
    assign mag_im_c = num_im_c[PW-1] ? -num_im_c : num_im_c;

    assign step_re = div_step(rem_re, den);
    assign step_im = div_step(rem_im, den);

    assign res_re = saturate(quot_mag(quot_re), neg_re, pre_ovf_re);
    assign res_im = saturate(quot_mag(quot_im), neg_im, pre_ovf_im);

    // Datapath: capture at accept, form products in MULT, iterate in DIV.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (accept) begin
                    a_re <= a_i[2*WIDTH-1:WIDTH];
                    a_im <= a_i[WIDTH-1:0];
                    b_re <= b_i[2*WIDTH-1:WIDTH];
                    b_im <= b_i[WIDTH-1:0];
                end
            end
            MULT: begin
                den        <= den_c[2*WIDTH-1:0];
                den_zero   <= den_zero_c;
                neg_re     <= num_re_c[PW-1];
                neg_im     <= num_im_c[PW-1];
                pre_ovf_re <= (mag_re_c >= {den_c[2*WIDTH-1:0], 1'b0});
                pre_ovf_im <= (mag_im_c >= {den_c[2*WIDTH-1:0], 1'b0});
                rem_re     <= {1'b0, mag_re_c};
                rem_im     <= {1'b0, mag_im_c};
                quot_re    <= '0;
                quot_im    <= '0;
            end
            DIV: begin
                rem_re  <= step_re[RW-1:0];
                rem_im  <= step_im[RW-1:0];
                quot_re <= {quot_re[ITERS-2:0], step_re[RW]};
                quot_im <= {quot_im[ITERS-2:0], step_im[RW]};
            end
            default: begin
            end
        endcase
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q_o       <= '0;
            ovf_o     <= 1'b0;
            dbz_o     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        state    <= MULT;
                    end
                end
                MULT: begin
                    cnt   <= '0;
                    state <= den_zero_c ? DONE : DIV;
                end
                DIV: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(ITERS - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        if (den_zero) begin
                            q_o   <= {dbz_val(a_re), dbz_val(a_im)};
                            ovf_o <= 1'b0;
                            dbz_o <= 1'b1;
                        end else begin
                            q_o   <= {res_re[WIDTH-1:0], res_im[WIDTH-1:0]};
                            ovf_o <= res_re[WIDTH] | res_im[WIDTH];
                            dbz_o <= 1'b0;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_complex_div.sv
// tb_complex_div: directed vectors with hand-computed quotients, handshake,
// backpressure and mid-operation reset, plus random operands checked against
// a real-valued reference.
module tb_complex_div;

    localparam int WIDTH = 32;
`ifdef COMPLEX_DIV_ROUND_EN
    localparam int  LAT = 35;
    localparam real TOL = 0.5;
`else
    localparam int  LAT = 34;
    localparam real TOL = 1.0;
`endif
    // The real-valued reference itself carries about 2^-20 LSB of rounding noise.
    localparam real EPS = 1.0e-5;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [2*WIDTH-1:0] a_i;
    logic [2*WIDTH-1:0] b_i;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] q_o;
    logic               ovf_o;
    logic               dbz_o;

    int checks;
    int failures;

    complex_div #(.WIDTH(WIDTH), .FRAC(31)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .b_i       (b_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_o       (q_o),
        .ovf_o     (ovf_o),
        .dbz_o     (dbz_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present operands, wait for the accepting edge, then count edges until out_valid.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          output int lat, output logic busy);
        a_i      = a;
        b_i      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        busy     = in_ready;
        a_i      = 64'hDEAD_BEEF_0BAD_F00D;
        b_i      = 64'h1357_9BDF_2468_ACE0;
        lat      = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic directed(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] exp_q, input logic exp_ovf,
                            input logic exp_dbz, input int exp_lat);
        int   lat;
        logic busy;
        run_op(a, b, lat, busy);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_q"}, q_o, exp_q);
        check({tag, "_ovf"}, 64'(ovf_o), 64'(exp_ovf));
        check({tag, "_dbz"}, 64'(dbz_o), 64'(exp_dbz));
        @(posedge clk);
        #1;
        check({tag, "_idle"}, 64'({out_valid, in_ready}), 64'd1);
    endtask

    function automatic real clamp(input real x);
        if (x > 2147483647.0) return 2147483647.0;
        if (x < -2147483648.0) return -2147483648.0;
        return x;
    endfunction

    function automatic real absr(input real x);
        return (x < 0.0) ? -x : x;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int         lat;
        logic       busy;
        logic [63:0] held_q;
        logic        held_ovf;
        logic        held_dbz;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_i       = '0;
        b_i       = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_q", q_o, 64'd0);
        check("rst_flags", 64'({ovf_o, dbz_o}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 0.25 / 0.5 = 0.5
        directed("t1", 64'h20000000_00000000, 64'h40000000_00000000,
                 64'h40000000_00000000, 1'b0, 1'b0, LAT);
        // j0.25 / j0.5 = 0.5
        directed("t2a", 64'h00000000_20000000, 64'h00000000_40000000,
                 64'h40000000_00000000, 1'b0, 1'b0, LAT);
        // 0.25 / j0.5 = -j0.5
        directed("t2b", 64'h20000000_00000000, 64'h00000000_40000000,
                 64'h00000000_C0000000, 1'b0, 1'b0, LAT);
        // (0.5 - j0.5) / 0.25 = 2 - j2, both saturate
        directed("t3", 64'h40000000_C0000000, 64'h20000000_00000000,
                 64'h7FFFFFFF_80000000, 1'b1, 1'b0, LAT);
        // divide by zero
        directed("t4a", 64'h20000000_E0000000, 64'h00000000_00000000,
                 64'h7FFFFFFF_80000000, 1'b0, 1'b1, 2);
        directed("t4b", 64'h00000000_00000000, 64'h00000000_00000000,
                 64'h00000000_00000000, 1'b0, 1'b1, 2);

        // Backpressure: result held while out_ready is low, new requests ignored.
        out_ready = 1'b0;
        run_op(64'h20000000_00000000, 64'h00000000_40000000, lat, busy);
        check("bp_lat", 64'(lat), 64'(LAT));
        held_q   = q_o;
        held_ovf = ovf_o;
        held_dbz = dbz_o;
        check("bp_q", held_q, 64'h00000000_C0000000);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            a_i      = {$urandom, $urandom};
            b_i      = {$urandom, $urandom};
            @(posedge clk);
            #1;
            check($sformatf("bp_q_stable%0d", k), q_o, held_q);
            check($sformatf("bp_flags%0d", k), 64'({ovf_o, dbz_o}), 64'({held_ovf, held_dbz}));
            check($sformatf("bp_hs%0d", k), 64'({out_valid, in_ready}), 64'd2);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", 64'({out_valid, in_ready}), 64'd1);
        directed("bp_next", 64'h00000000_20000000, 64'h00000000_40000000,
                 64'h40000000_00000000, 1'b0, 1'b0, LAT);

        // Reset during DIV iteration 10 discards the operation.
        a_i      = 64'h20000000_00000000;
        b_i      = 64'h40000000_00000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("mid_busy", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_q", q_o, 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        directed("after_rst", 64'h20000000_00000000, 64'h40000000_00000000,
                 64'h40000000_00000000, 1'b0, 1'b0, LAT);

        // Random operands against a real-valued reference.
        for (int i = 0; i < 300; i++) begin
            int  ar, ai, br, bi, gr, gi;
            real den, ire, iim, er, ei;
            logic ok_re, ok_im;
            ar = int'($urandom);
            ai = int'($urandom);
            br = int'($urandom);
            bi = int'($urandom);
            case (i % 4)
                1: begin ar = ar >>> 2; ai = ai >>> 2; end
                2: begin ar = ar >>> 9; ai = ai >>> 9; end
                3: begin br = br >>> 12; bi = bi >>> 12; ar = ar >>> 14; ai = ai >>> 14; end
                default: begin end
            endcase
            if (br == 0 && bi == 0) br = 1;
            run_op({ar, ai}, {br, bi}, lat, busy);
            den = $itor(br) * $itor(br) + $itor(bi) * $itor(bi);
            ire = ($itor(ar) * $itor(br) + $itor(ai) * $itor(bi)) / den * 2147483648.0;
            iim = ($itor(ai) * $itor(br) - $itor(ar) * $itor(bi)) / den * 2147483648.0;
            gr  = int'(q_o[63:32]);
            gi  = int'(q_o[31:0]);
            er  = $itor(gr) - clamp(ire);
            ei  = $itor(gi) - clamp(iim);
            ok_re = (absr(er) <= TOL + EPS) && (TOL < 1.0 || absr(er) < 1.0);
            ok_im = (absr(ei) <= TOL + EPS) && (TOL < 1.0 || absr(ei) < 1.0);
            if (TOL >= 1.0) begin
                ok_re = absr(er) < 1.0 + EPS;
                ok_im = absr(ei) < 1.0 + EPS;
            end
            check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(LAT));
            check($sformatf("rnd%0d_re q=%h ideal=%f", i, q_o[63:32], ire), 64'(ok_re), 64'd1);
            check($sformatf("rnd%0d_im q=%h ideal=%f", i, q_o[31:0], iim), 64'(ok_im), 64'd1);
            check($sformatf("rnd%0d_dbz", i), 64'(dbz_o), 64'd0);
            if (absr(ire) >= 2147483650.0 || absr(iim) >= 2147483650.0) begin
                check($sformatf("rnd%0d_ovf_set", i), 64'(ovf_o), 64'd1);
            end else if (absr(ire) <= 2147483645.0 && absr(iim) <= 2147483645.0) begin
                check($sformatf("rnd%0d_ovf_clr", i), 64'(ovf_o), 64'd0);
            end
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
